// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data_mem port between CPU (port 0) and DMA (port 1)
// with round-robin arbitration, lock for atomic RMW and in-order latency-matched responses.
module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic                     req0_lock,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic                     req1_lock,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    output logic                     mem_WE,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [RD_LATENCY-1:0]   pv_q, pv_d, pp_q, pp_d, pr_q, pr_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                    gnt0, gnt1, accept, sel, sel_we, sel_lock;
    logic [DATA_WIDTH-1:0]   ret_data;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            LOCK0:   gnt0 = req0_valid;
            LOCK1:   gnt1 = req1_valid;
            default: begin
                gnt0 = req0_valid & (!req1_valid | last_grant_q);
                gnt1 = req1_valid & (!req0_valid | !last_grant_q);
            end
        endcase
        // ready must stay low for the whole reset assertion, not just after the edge
        gnt0 = gnt0 & RST;
        gnt1 = gnt1 & RST;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign sel        = gnt1;
    assign sel_we     = sel ? req1_we : req0_we;
    assign sel_lock   = sel ? req1_lock : req0_lock;
    assign mem_A      = accept ? (sel ? req1_addr : req0_addr) : '0;
    assign mem_WD     = accept ? (sel ? req1_wdata : req0_wdata) : '0;
    assign mem_WE     = accept & sel_we;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = sel;
            state_d      = sel_lock ? (sel ? LOCK1 : LOCK0) : ARB;
        end
    end

    always_comb begin
        pv_d    = pv_q;
        pp_d    = pp_q;
        pr_d    = pr_q;
        pv_d[0] = accept;
        pp_d[0] = sel;
        pr_d[0] = !sel_we;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pp_d[i] = pp_q[i-1];
            pr_d[i] = pr_q[i-1];
        end
    end

    assign rsp0_valid = pv_q[RD_LATENCY-1] & !pp_q[RD_LATENCY-1];
    assign rsp1_valid = pv_q[RD_LATENCY-1] & pp_q[RD_LATENCY-1];
    assign ret_data   = pr_q[RD_LATENCY-1] ? mem_RD : '0;
    assign rdata0_d   = rsp0_valid ? ret_data : rdata0_q;
    assign rdata1_d   = rsp1_valid ? ret_data : rdata1_q;
    assign rsp0_rdata = rdata0_d;
    assign rsp1_rdata = rdata1_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            pv_q         <= '0;
            pp_q         <= '0;
            pr_q         <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pv_q         <= pv_d;
            pp_q         <= pp_d;
            pr_q         <= pr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end
endmodule
